// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtract controller: controller state
// encoding and the number of bits processed per slice cycle.
package serial_sub_pkg;

  localparam int SLICE_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_slice2.sv
// 2-bit subtract slice: s = a + ~b + cin, built from two ripple full adders.
// The full adder lives here because the slice is its only user.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module sub_slice2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [1:0] b_inv_s;
  logic       c_mid_s;

  assign b_inv_s = ~b;

  full_adder u_fa0 (
    .a    (a[0]),
    .b    (b_inv_s[0]),
    .cin  (cin),
    .s    (s[0]),
    .cout (c_mid_s)
  );

  full_adder u_fa1 (
    .a    (a[1]),
    .b    (b_inv_s[1]),
    .cin  (c_mid_s),
    .s    (s[1]),
    .cout (cout)
  );

endmodule

// File: rtl/serial_sub_ctrl.sv
// Serial subtractor controller: computes a - b two bits per cycle, LSB pair
// first, with the inter-slice carry held in a flop. start/busy/done handshake.
// Optional macro SERIAL_SUB_FLAGS_EN adds zero/neg/ovf result flags.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             cout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / SLICE_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("serial_sub_ctrl: WIDTH must be even and >= 2");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               cout_q, cout_d;

  logic [1:0]         slice_s;
  logic               slice_cout;
  logic [WIDTH+1:0]   acc_wide_s;
  logic [WIDTH-1:0]   acc_nx_s;

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic zero_q, zero_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;
`endif

  sub_slice2 u_slice (
    .a    (a_sh_q[1:0]),
    .b    (b_sh_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New sum pair enters the accumulator from the top; after STEPS shifts the
  // first pair computed sits at bit 0.
  assign acc_wide_s = {slice_s, acc_q};
  assign acc_nx_s   = acc_wide_s[WIDTH+1:2];

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    cout_d  = cout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_FLAGS_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> SLICE_BITS;
        b_sh_d  = b_sh_q >> SLICE_BITS;
        acc_d   = acc_nx_s;
        carry_d = slice_cout;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          diff_d  = acc_nx_s;
          cout_d  = slice_cout;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = (acc_nx_s == '0);
          neg_d   = acc_nx_s[WIDTH-1];
          ovf_d   = (a_msb_q != b_msb_q) && (acc_nx_s[WIDTH-1] != a_msb_q);
`endif
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs; async reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      cout_q  <= cout_d;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign cout = cout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

endmodule
